demux_reg4: RTL and testbench



---
 rtl/demux_reg4_pkg.sv | 23 ++
 rtl/demux_reg4_lane_slot.sv | 47 ++++
 rtl/demux_reg4.sv | 81 ++++++++
 tb/tb_demux_reg4.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/demux_reg4_pkg.sv
// Shared constants and helpers for the registered 1-to-4 demultiplexer.
package demux_reg4_pkg;

   localparam int unsigned LANES  = 4;
   localparam int unsigned SEL_W  = 2;
   localparam int unsigned PEND_W = 3;

   localparam int unsigned LANE_A = 0;
   localparam int unsigned LANE_B = 1;
   localparam int unsigned LANE_C = 2;
   localparam int unsigned LANE_D = 3;

   // Number of lanes currently holding a word.
   function automatic logic [PEND_W-1:0] count_valid(input logic [LANES-1:0] v);
      logic [PEND_W-1:0] sum;
      sum = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         sum = sum + PEND_W'(v[i]);
      end
      return sum;
   endfunction

endpackage

// File: rtl/demux_reg4_lane_slot.sv
// One holding lane: data register plus a valid flag set on load, cleared by ack or flush.
module lane_slot #(
   parameter int unsigned DATA_WIDTH = 7
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  ack,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  valid
);

   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;

   // Load wins over ack so a same-cycle replace keeps the lane valid.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (load) begin
         data_d = din;
      end
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
      end else if (ack) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign dout  = data_q;
   assign valid = valid_q;

endmodule

// File: rtl/demux_reg4.sv
// Registered 1-to-4 demultiplexer with manual or round-robin lane selection
// and per-lane backpressure.
module demux_reg4
   import demux_reg4_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 7
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SEL_W-1:0]      select,
   input  logic                  auto_mode,
   input  logic                  clear,
   output logic [DATA_WIDTH-1:0] out_a,
   output logic [DATA_WIDTH-1:0] out_b,
   output logic [DATA_WIDTH-1:0] out_c,
   output logic [DATA_WIDTH-1:0] out_d,
   output logic [LANES-1:0]      out_valid,
   input  logic [LANES-1:0]      out_ack,
   output logic [SEL_W-1:0]      ptr,
   output logic [PEND_W-1:0]     pending
);

   logic [SEL_W-1:0]      ptr_q, ptr_d;
   logic [SEL_W-1:0]      tgt_c;
   logic                  accept_c;
   logic [LANES-1:0]      load_c;
   logic [LANES-1:0]      lane_valid;
   logic [DATA_WIDTH-1:0] lane_data [LANES];

   // Ack on the target lane frees it in the same cycle, allowing a replace.
   always_comb begin
      tgt_c    = auto_mode ? ptr_q : select;
      in_ready = ~reset & ~clear & (~lane_valid[tgt_c] | out_ack[tgt_c]);
      accept_c = in_valid & in_ready;
      load_c   = '0;
      if (accept_c) begin
         load_c[tgt_c] = 1'b1;
      end
      ptr_d = ptr_q;
      if (clear) begin
         ptr_d = '0;
      end else if (accept_c && auto_mode) begin
         ptr_d = ptr_q + SEL_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      lane_slot #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_slot (
         .clock (clock),
         .reset (reset),
         .load  (load_c[i]),
         .ack   (out_ack[i]),
         .clear (clear),
         .din   (in_data),
         .dout  (lane_data[i]),
         .valid (lane_valid[i])
      );
   end

   assign out_a     = lane_data[LANE_A];
   assign out_b     = lane_data[LANE_B];
   assign out_c     = lane_data[LANE_C];
   assign out_d     = lane_data[LANE_D];
   assign out_valid = lane_valid;
   assign ptr       = ptr_q;
   assign pending   = count_valid(lane_valid);

endmodule

// File: tb/tb_demux_reg4.sv
// Directed self-checking bench for demux_reg4.
module tb_demux_reg4;

   logic       clk;
   logic       rst;
   logic [6:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] select;
   logic       auto_mode;
   logic       clear;
   logic [6:0] out_a, out_b, out_c, out_d;
   logic [3:0] out_valid;
   logic [3:0] out_ack;
   logic [1:0] ptr;
   logic [2:0] pending;

   int errors = 0;
   int checks = 0;

   demux_reg4 #(.DATA_WIDTH(7)) dut (
      .clock     (clk),
      .reset     (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .select    (select),
      .auto_mode (auto_mode),
      .clear     (clear),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_c     (out_c),
      .out_d     (out_d),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .ptr       (ptr),
      .pending   (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Let one rising edge pass; return just after the following falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      select   = 2'd0;
      #3;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
      checks++; if ({out_a, out_b, out_c, out_d} !== 28'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", {out_a, out_b, out_c, out_d}); end
      checks++; if ({out_valid, ptr, pending} !== 9'h0) begin errors++; $display("FAIL reset_state got=%h exp=0", {out_valid, ptr, pending}); end
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_manual();
      auto_mode = 1'b0; select = 2'd2; in_data = 7'h11; in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL manual_ready got=%b exp=1", in_ready); end
      cyc();
      in_valid = 1'b0;
      checks++; if (out_c !== 7'h11) begin errors++; $display("FAIL manual_out_c got=%h exp=11", out_c); end
      checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL manual_valid got=%b exp=0100", out_valid); end
      checks++; if (pending !== 3'd1) begin errors++; $display("FAIL manual_pending got=%0d exp=1", pending); end
      checks++; if ({out_a, out_b, out_d} !== 21'h0) begin errors++; $display("FAIL manual_others got=%h exp=0", {out_a, out_b, out_d}); end
      checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL manual_ptr got=%0d exp=0", ptr); end
   endtask

   task automatic test_backpressure();
      select = 2'd2; in_data = 7'h22; in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
      cyc();
      checks++; if (out_c !== 7'h11) begin errors++; $display("FAIL bp_hold got=%h exp=11", out_c); end
      out_ack = 4'b0100;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_ack got=%b exp=1", in_ready); end
      cyc();
      in_valid = 1'b0; out_ack = 4'b0000;
      checks++; if (out_c !== 7'h22) begin errors++; $display("FAIL bp_replace got=%h exp=22", out_c); end
      checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL bp_valid got=%b exp=0100", out_valid); end
      out_ack = 4'b0100;
      cyc();
      out_ack = 4'b0000;
      checks++; if (out_valid !== 4'b0000 || pending !== 3'd0) begin errors++; $display("FAIL bp_drain got=%b/%0d exp=0000/0", out_valid, pending); end
   endtask

   task automatic test_round_robin();
      auto_mode = 1'b1; select = 2'd3;
      for (int i = 0; i < 4; i++) begin
         in_data = 7'(i + 1); in_valid = 1'b1;
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rr_ready%0d got=%b exp=1", i, in_ready); end
         cyc();
      end
      checks++; if ({out_a, out_b, out_c, out_d} !== {7'h01, 7'h02, 7'h03, 7'h04}) begin errors++; $display("FAIL rr_data got=%h exp=%h", {out_a, out_b, out_c, out_d}, {7'h01, 7'h02, 7'h03, 7'h04}); end
      checks++; if (out_valid !== 4'b1111 || pending !== 3'd4) begin errors++; $display("FAIL rr_full got=%b/%0d exp=1111/4", out_valid, pending); end
      checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL rr_wrap got=%0d exp=0", ptr); end
      in_data = 7'h05;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rr_stall_ready got=%b exp=0", in_ready); end
      cyc();
      checks++; if (out_a !== 7'h01 || ptr !== 2'd0) begin errors++; $display("FAIL rr_stall_hold got=%h/%0d exp=01/0", out_a, ptr); end
      out_ack = 4'b0001;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rr_unstall_ready got=%b exp=1", in_ready); end
      cyc();
      in_valid = 1'b0; out_ack = 4'b0000;
      checks++; if (out_a !== 7'h05 || out_valid !== 4'b1111 || ptr !== 2'd1) begin errors++; $display("FAIL rr_unstall got=%h/%b/%0d exp=05/1111/1", out_a, out_valid, ptr); end
   endtask

   task automatic test_ack();
      out_ack = 4'b1010;
      cyc();
      out_ack = 4'b0000;
      checks++; if (out_valid !== 4'b0101 || pending !== 3'd2) begin errors++; $display("FAIL ack_pair got=%b/%0d exp=0101/2", out_valid, pending); end
      out_ack = 4'b0010;
      cyc();
      out_ack = 4'b0000;
      checks++; if (out_valid !== 4'b0101 || pending !== 3'd2) begin errors++; $display("FAIL ack_invalid got=%b/%0d exp=0101/2", out_valid, pending); end
      checks++; if (out_b !== 7'h02) begin errors++; $display("FAIL ack_data_kept got=%h exp=02", out_b); end
   endtask

   task automatic test_clear();
      auto_mode = 1'b1; in_data = 7'h33; in_valid = 1'b1;
      cyc();
      auto_mode = 1'b0; select = 2'd3; in_data = 7'h44;
      cyc();
      in_valid = 1'b0;
      checks++; if (out_valid !== 4'b1111 || ptr !== 2'd2) begin errors++; $display("FAIL clr_setup got=%b/%0d exp=1111/2", out_valid, ptr); end
      clear = 1'b1; in_valid = 1'b1; auto_mode = 1'b1; in_data = 7'h7f; out_ack = 4'b1111;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got=%b exp=0", in_ready); end
      cyc();
      clear = 1'b0; in_valid = 1'b0; out_ack = 4'b0000;
      checks++; if (out_valid !== 4'b0000 || ptr !== 2'd0 || pending !== 3'd0) begin errors++; $display("FAIL clr_state got=%b/%0d/%0d exp=0000/0/0", out_valid, ptr, pending); end
      checks++; if ({out_a, out_b, out_c, out_d} !== {7'h05, 7'h33, 7'h03, 7'h44}) begin errors++; $display("FAIL clr_data got=%h exp=%h", {out_a, out_b, out_c, out_d}, {7'h05, 7'h33, 7'h03, 7'h44}); end
   endtask

   task automatic test_async_reset();
      auto_mode = 1'b1; in_valid = 1'b1;
      in_data = 7'h10; cyc();
      in_data = 7'h20; cyc();
      in_data = 7'h30;
      #2;
      rst = 1'b1;
      #1;
      checks++; if ({out_a, out_b, out_c, out_d} !== 28'h0) begin errors++; $display("FAIL arst_data got=%h exp=0", {out_a, out_b, out_c, out_d}); end
      checks++; if ({out_valid, ptr, pending, in_ready} !== 10'h0) begin errors++; $display("FAIL arst_state got=%h exp=0", {out_valid, ptr, pending, in_ready}); end
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      in_data = 7'h55; in_valid = 1'b1; select = 2'd3;
      cyc();
      in_valid = 1'b0;
      checks++; if (out_a !== 7'h55 || out_valid !== 4'b0001 || ptr !== 2'd1) begin errors++; $display("FAIL arst_first got=%h/%b/%0d exp=55/0001/1", out_a, out_valid, ptr); end
   endtask

   initial begin
      rst = 1'b1; in_data = '0; in_valid = 1'b0; select = '0;
      auto_mode = 1'b0; clear = 1'b0; out_ack = '0;
      test_reset();
      test_manual();
      test_backpressure();
      test_round_robin();
      test_ack();
      test_clear();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
